irb_conv_scheduler: RTL
=======================

IRB_CONV_SCHEDULER -- requirements
Module: irb_conv_scheduler

Interface
REQ-001 SHALL have parameter TILE_W, default 8: width of tile counter and tile index ports.
REQ-002 SHALL have parameter GRP_W, default 6: width of kernel-group counter and group index ports.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-004 start  in  1  one-cycle pulse; begins a layer; ignored unless IDLE.
REQ-005 n_tiles  in  TILE_W  spatial tiles in the layer; sampled on accepted start.
REQ-006 n_grp  in  GRP_W  kernel groups (Npar output channels each) per tile; sampled on accepted start.
REQ-007 nif_cfg  in  11  input channel count; sampled on accepted start.
REQ-008 size_kex_cfg  in  $clog2(KEX_N_ELEM+1)  elements per expansion kernel; sampled on accepted start.
REQ-009 ld_fmi_req  out  1; ld_fmi_tile  out  TILE_W; ld_fmi_ack  in  1: FMI tile load handshake.
REQ-010 ld_kex_req  out  1; ld_kex_grp  out  GRP_W; ld_kex_ack  in  1: KEX group load handshake.
REQ-011 conv_start  out  1; conv_nif  out  11; conv_size_kex  out  $clog2(KEX_N_ELEM+1); conv_finish  in  1: 1x1 convolution engine control.
REQ-012 st_req  out  1; st_tile  out  TILE_W; st_grp  out  GRP_W; st_ack  in  1: FMINT store handshake.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when the layer completes.

Function
REQ-015 SHALL implement states IDLE, LOAD, CONV_START, CONV_WAIT, STORE and DONE, with registered outputs.
REQ-016 IDLE->LOAD on start; tile=0, grp=0; config registers latched; LOAD entered the next cycle.
REQ-017 If start arrives with n_tiles==0 or n_grp==0, IDLE->DONE: no requests issued, done pulses the next cycle.
REQ-018 In LOAD, ld_kex_req SHALL assert; ld_fmi_req SHALL assert only when grp==0, so FMI loads once per tile.
REQ-019 Each req SHALL stay high until its ack is sampled high, then drop the next cycle; req never re-asserts within the same LOAD visit.
REQ-020 Acks may arrive in any order or in the same cycle; LOAD->CONV_START the cycle after every issued req has been acked.
REQ-021 An ack received while its req is low SHALL be ignored.
REQ-022 CONV_START SHALL drive conv_start for exactly one cycle, then go to CONV_WAIT.
REQ-023 conv_nif and conv_size_kex SHALL equal the latched config at all times while busy.
REQ-024 CONV_WAIT->STORE on conv_finish; st_req then follows the REQ-019 rule, with st_tile and st_grp equal to the current indices.
REQ-025 On st_ack: if grp==n_grp-1, set grp=0; then if tile==n_tiles-1 go to DONE, else tile+1 and go to LOAD; otherwise grp+1 and go to LOAD.
REQ-026 DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-027 Index ports SHALL be stable for the whole time their req is high.
REQ-028 Counter comparisons are unsigned at TILE_W/GRP_W; maximum n_tiles=2^TILE_W-1 with no wrap.

Reset
REQ-029 On rst: state IDLE; all req, conv_start and done low; busy low; indices and config registers zero.
REQ-030 rst mid-operation SHALL abort immediately with no completion pulse; acks or conv_finish arriving after reset are ignored.

Configuration
REQ-031 With IRB_SCHED_PERF_EN defined: output perf_cycles (32 bits) and output perf_stall (32 bits).
REQ-032 perf_cycles counts busy cycles; perf_stall counts LOAD+STORE cycles with an unacked req.
REQ-033 Both counters clear on an accepted start and on rst, and saturate at all-ones.
REQ-034 Without IRB_SCHED_PERF_EN, the counter ports and logic SHALL be absent and behaviour is otherwise identical.

Structure
REQ-035 irb_pkg SHALL hold the sched_state_t typedef, TILE_W/GRP_W defaults and existing constants (KEX_N_ELEM, Npar).
REQ-036 The req/ack hold logic SHALL be a sub-module sched_req_port (inputs issue and ack; outputs req and complete), instantiated three times.

Verification
REQ-037 n_tiles=2, n_grp=3, acks after 2 cycles, conv_finish after 10 cycles -> 2 FMI loads, 6 KEX loads, 6 conv_start, 6 stores in (tile,grp) order (0,0)..(1,2), one done.
REQ-038 ld_fmi_ack and ld_kex_ack in the same cycle -> conv_start exactly 2 cycles after the acks.
REQ-039 n_tiles=0 -> done 2 cycles after start; no req or conv_start seen.
REQ-040 rst asserted in CONV_WAIT, then conv_finish pulsed -> stays IDLE, all outputs low, no done.
REQ-041 start pulsed while busy, plus a spurious st_ack in LOAD -> no effect; sequence matches REQ-037.
REQ-042 With IRB_SCHED_PERF_EN, n_tiles=1, n_grp=1, each ack after 3 cycles, finish after 5 -> perf_stall equals the counted req-high cycles and perf_cycles equals the start-to-done cycle count.

Source files
------------

// File: rtl/irb_pkg.sv
// Shared types and constants for the IRB convolution layer scheduler.
package irb_pkg;

    localparam int KEX_N_ELEM = 64;
    localparam int Npar       = 8;
    localparam int SIZE_KEX_W = $clog2(KEX_N_ELEM + 1);
    localparam int NIF_W      = 11;
    localparam int TILE_W_DEF = 8;
    localparam int GRP_W_DEF  = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV_START,
        S_CONV_WAIT,
        S_STORE,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/irb_conv_scheduler_if.sv
// Load, convolution-engine and store handshakes between the scheduler and its datapath.
interface irb_conv_scheduler_if
    import irb_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEF,
    parameter int GRP_W  = GRP_W_DEF
);
    logic                  ld_fmi_req;
    logic [TILE_W-1:0]     ld_fmi_tile;
    logic                  ld_fmi_ack;
    logic                  ld_kex_req;
    logic [GRP_W-1:0]      ld_kex_grp;
    logic                  ld_kex_ack;
    logic                  conv_start;
    logic [NIF_W-1:0]      conv_nif;
    logic [SIZE_KEX_W-1:0] conv_size_kex;
    logic                  conv_finish;
    logic                  st_req;
    logic [TILE_W-1:0]     st_tile;
    logic [GRP_W-1:0]      st_grp;
    logic                  st_ack;

    modport master (
        output ld_fmi_req, ld_fmi_tile, input ld_fmi_ack,
        output ld_kex_req, ld_kex_grp, input ld_kex_ack,
        output conv_start, conv_nif, conv_size_kex, input conv_finish,
        output st_req, st_tile, st_grp, input st_ack
    );

    modport slave (
        input ld_fmi_req, ld_fmi_tile, output ld_fmi_ack,
        input ld_kex_req, ld_kex_grp, output ld_kex_ack,
        input conv_start, conv_nif, conv_size_kex, output conv_finish,
        input st_req, st_tile, st_grp, output st_ack
    );
endinterface

// File: rtl/sched_req_port.sv
// One request/acknowledge port: raises req while issue is held, drops it after the ack,
// and reports completion until issue is released so the request fires once per visit.
module sched_req_port (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic ack,
    output logic req,
    output logic complete
);

    always_ff @(posedge clk) begin
        if (rst) begin
            req      <= 1'b0;
            complete <= 1'b0;
        end else if (!issue) begin
            req      <= 1'b0;
            complete <= 1'b0;
        end else if (req && ack) begin
            req      <= 1'b0;
            complete <= 1'b1;
        end else if (!complete) begin
            req      <= 1'b1;
        end
    end

endmodule

// File: rtl/irb_conv_scheduler.sv
// Layer scheduler: walks tiles x kernel groups through load, 1x1 convolution and store.
// Optional perf counters (perf_cycles, perf_stall) are built when IRB_SCHED_PERF_EN is defined.
module irb_conv_scheduler
    import irb_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEF,
    parameter int GRP_W  = GRP_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TILE_W-1:0]     n_tiles,
    input  logic [GRP_W-1:0]      n_grp,
    input  logic [NIF_W-1:0]      nif_cfg,
    input  logic [SIZE_KEX_W-1:0] size_kex_cfg,
    output logic                  busy,
    output logic                  done,
`ifdef IRB_SCHED_PERF_EN
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stall,
`endif
    irb_conv_scheduler_if.master  bus
);

    sched_state_t          state;
    logic [TILE_W-1:0]     tile_q, n_tiles_q;
    logic [GRP_W-1:0]      grp_q, n_grp_q;
    logic [NIF_W-1:0]      nif_q;
    logic [SIZE_KEX_W-1:0] size_kex_q;
    logic                  conv_start_q;
    logic                  fmi_issue, kex_issue, st_issue;
    logic                  fmi_cmp, kex_cmp, st_cmp;
    logic                  load_ok;

    // The feature-map tile is shared by all kernel groups, so it is only fetched at grp 0.
    assign fmi_issue = (state == S_LOAD) && (grp_q == '0);
    assign kex_issue = (state == S_LOAD);
    assign st_issue  = (state == S_STORE);
    assign load_ok   = kex_cmp && (fmi_cmp || !fmi_issue);

    sched_req_port u_fmi_port (.clk(clk), .rst(rst), .issue(fmi_issue), .ack(bus.ld_fmi_ack),
                               .req(bus.ld_fmi_req), .complete(fmi_cmp));
    sched_req_port u_kex_port (.clk(clk), .rst(rst), .issue(kex_issue), .ack(bus.ld_kex_ack),
                               .req(bus.ld_kex_req), .complete(kex_cmp));
    sched_req_port u_st_port  (.clk(clk), .rst(rst), .issue(st_issue), .ack(bus.st_ack),
                               .req(bus.st_req), .complete(st_cmp));

    assign bus.ld_fmi_tile   = tile_q;
    assign bus.ld_kex_grp    = grp_q;
    assign bus.st_tile       = tile_q;
    assign bus.st_grp        = grp_q;
    assign bus.conv_start    = conv_start_q;
    assign bus.conv_nif      = nif_q;
    assign bus.conv_size_kex = size_kex_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            conv_start_q <= 1'b0;
            tile_q       <= '0;
            grp_q        <= '0;
            n_tiles_q    <= '0;
            n_grp_q      <= '0;
            nif_q        <= '0;
            size_kex_q   <= '0;
        end else begin
            done         <= 1'b0;
            conv_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_tiles_q  <= n_tiles;
                        n_grp_q    <= n_grp;
                        nif_q      <= nif_cfg;
                        size_kex_q <= size_kex_cfg;
                        tile_q     <= '0;
                        grp_q      <= '0;
                        busy       <= 1'b1;
                        state      <= (n_tiles == '0 || n_grp == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_ok) begin
                        conv_start_q <= 1'b1;
                        state        <= S_CONV_START;
                    end
                end
                S_CONV_START: state <= S_CONV_WAIT;
                S_CONV_WAIT: begin
                    if (bus.conv_finish) state <= S_STORE;
                end
                S_STORE: begin
                    if (st_cmp) begin
                        if (grp_q == n_grp_q - GRP_W'(1)) begin
                            grp_q <= '0;
                            if (tile_q == n_tiles_q - TILE_W'(1)) begin
                                state <= S_DONE;
                            end else begin
                                tile_q <= tile_q + TILE_W'(1);
                                state  <= S_LOAD;
                            end
                        end else begin
                            grp_q <= grp_q + GRP_W'(1);
                            state <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef IRB_SCHED_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic stall;
    assign stall = ((state == S_LOAD) || (state == S_STORE)) &&
                   (bus.ld_fmi_req || bus.ld_kex_req || bus.st_req);

    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && start)) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy)  perf_cycles <= sat_inc(perf_cycles);
            if (stall) perf_stall  <= sat_inc(perf_stall);
        end
    end
`endif

endmodule
